// File: rtl/wb_stage_if.sv
// Writeback-stage bus: MEM-side handshake and operands, load return, register-file write port and retire counter.
interface wb_stage_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [REG_AW-1:0] in_rd;
   logic              in_regwrite;
   logic [1:0]        in_wb_sel;
   logic [XLEN-1:0]   in_alu;
   logic [XLEN-1:0]   in_pc4;
   logic [XLEN-1:0]   in_csr;
   logic [2:0]        in_funct3;
   logic [2:0]        in_boff;
   logic              ld_valid;
   logic [XLEN-1:0]   ld_data;
   logic              flush;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;
   logic [CNT_W-1:0]  instret;

   modport master (
      output in_valid, in_rd, in_regwrite, in_wb_sel, in_alu, in_pc4, in_csr,
             in_funct3, in_boff, ld_valid, ld_data, flush,
      input  in_ready, rf_we, rf_waddr, rf_wdata, instret
   );

   modport slave (
      input  in_valid, in_rd, in_regwrite, in_wb_sel, in_alu, in_pc4, in_csr,
             in_funct3, in_boff, ld_valid, ld_data, flush,
      output in_ready, rf_we, rf_waddr, rf_wdata, instret
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: result select, load extension, load-return stall, register-file write and instret counter.
module wb_stage #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 64
) (
   input  logic       clk,
   input  logic       rst,
   wb_stage_if.slave  bus
);

   typedef enum logic {IDLE, WAIT_LD} state_t;

   state_t            state;
   logic [REG_AW-1:0] p_rd;
   logic              p_regwrite;
   logic [2:0]        p_funct3;
   logic [2:0]        p_boff;

   logic              xfer_c;
   logic              commit_c;
   logic              we_c;
   logic              stall_ld_c;
   logic [REG_AW-1:0] c_rd;
   logic              c_regwrite;
   logic [XLEN-1:0]   c_data;

   // Lane select and sign/zero extension of a raw aligned memory word.
   function automatic logic [XLEN-1:0] load_ext(input logic [2:0]      f3,
                                                input logic [2:0]      boff,
                                                input logic [XLEN-1:0] d);
      logic [2:0]  off;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      off = (XLEN == 64) ? boff : {1'b0, boff[1:0]};
      b   = d[int'(off) * 8 +: 8];
      h   = d[int'(off[2:1]) * 16 +: 16];
      w   = d[int'(off[2]) * 32 +: 32];
      load_ext = d;
      case (f3)
         3'b000:  load_ext = XLEN'($signed(b));
         3'b100:  load_ext = XLEN'(b);
         3'b001:  load_ext = XLEN'($signed(h));
         3'b101:  load_ext = XLEN'(h);
         3'b010:  load_ext = (XLEN == 64) ? XLEN'($signed(w)) : d;
         3'b110:  load_ext = (XLEN == 64) ? XLEN'(w) : d;
         default: load_ext = d;
      endcase
   endfunction

   assign bus.in_ready = (state == IDLE) & ~bus.flush & ~rst;
   assign xfer_c       = bus.in_valid & bus.in_ready;

   // Decide whether this edge commits, and with which destination and data.
   always_comb begin
      commit_c   = 1'b0;
      stall_ld_c = 1'b0;
      c_rd       = bus.in_rd;
      c_regwrite = bus.in_regwrite;
      c_data     = bus.in_alu;
      if (state == IDLE) begin
         case (bus.in_wb_sel)
            2'b00:   c_data = bus.in_alu;
            2'b01:   c_data = load_ext(bus.in_funct3, bus.in_boff, bus.ld_data);
            2'b10:   c_data = bus.in_pc4;
            default: c_data = bus.in_csr;
         endcase
         stall_ld_c = xfer_c & (bus.in_wb_sel == 2'b01) & ~bus.ld_valid;
         commit_c   = xfer_c & ~stall_ld_c;
      end else begin
         c_rd       = p_rd;
         c_regwrite = p_regwrite;
         c_data     = load_ext(p_funct3, p_boff, bus.ld_data);
         commit_c   = bus.ld_valid & ~bus.flush;
      end
      we_c = commit_c & c_regwrite & (c_rd != '0);
   end

   // State, pending-load record and registered write port / retire counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         p_rd         <= '0;
         p_regwrite   <= 1'b0;
         p_funct3     <= '0;
         p_boff       <= '0;
         bus.rf_we    <= 1'b0;
         bus.rf_waddr <= '0;
         bus.rf_wdata <= '0;
         bus.instret  <= '0;
      end else begin
         bus.rf_we <= we_c;
         if (we_c) begin
            bus.rf_waddr <= c_rd;
            bus.rf_wdata <= c_data;
         end
         if (commit_c) begin
            bus.instret <= bus.instret + CNT_W'(1);
         end
         case (state)
            IDLE: begin
               if (stall_ld_c) begin
                  p_rd       <= bus.in_rd;
                  p_regwrite <= bus.in_regwrite;
                  p_funct3   <= bus.in_funct3;
                  p_boff     <= bus.in_boff;
                  state      <= WAIT_LD;
               end
            end
            WAIT_LD: begin
               if (bus.flush | bus.ld_valid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations plus randomized traffic against a transaction model.
module tb_wb_stage;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();
   wb_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(4))     bus2 ();

   wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut  (.clk(clk), .rst(rst), .bus(bus));
   wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(4))     dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // Narrow-counter copy sees identical traffic so instret wrap is exercised quickly.
   assign bus2.in_valid    = bus.in_valid;
   assign bus2.in_rd       = bus.in_rd;
   assign bus2.in_regwrite = bus.in_regwrite;
   assign bus2.in_wb_sel   = bus.in_wb_sel;
   assign bus2.in_alu      = bus.in_alu;
   assign bus2.in_pc4      = bus.in_pc4;
   assign bus2.in_csr      = bus.in_csr;
   assign bus2.in_funct3   = bus.in_funct3;
   assign bus2.in_boff     = bus.in_boff;
   assign bus2.ld_valid    = bus.ld_valid;
   assign bus2.ld_data     = bus.ld_data;
   assign bus2.flush       = bus.flush;

   int n_chk  = 0;
   int n_pass = 0;
   bit run    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference load extension from shifts and masks.
   function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [2:0] bo, input logic [31:0] d);
      int unsigned lane;
      logic [31:0] b, h;
      lane = int'(bo) % 4;
      b = (d >> (8 * lane)) & 32'hFF;
      h = (d >> (16 * (lane / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'd4:    return b;
         3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd5:    return h;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] m_sel(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] ld,
                                         input logic [31:0] pc4, input logic [31:0] csr);
      case (sel)
         2'd0:    return alu;
         2'd1:    return ld;
         2'd2:    return pc4;
         default: return csr;
      endcase
   endfunction

   // Transaction model: one pending load record and the expected write-port / counter values.
   bit              m_pend = 1'b0;
   logic [4:0]      m_rd;
   bit              m_rw;
   logic [2:0]      m_f3, m_bo;
   logic            e_we;
   logic [4:0]      e_wa;
   logic [31:0]     e_wd;
   logic [63:0]     e_cnt;

   task automatic m_commit(input logic [4:0] rd, input bit rw, input logic [31:0] data);
      e_cnt = e_cnt + 64'd1;
      if (rw && rd != 5'd0) begin
         e_we = 1'b1;
         e_wa = rd;
         e_wd = data;
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_pend = 1'b0;
         e_we = 1'b0; e_wa = '0; e_wd = '0; e_cnt = '0;
      end else begin
         e_we = 1'b0;
         if (m_pend) begin
            if (bus.flush) m_pend = 1'b0;
            else if (bus.ld_valid) begin
               m_commit(m_rd, m_rw, m_ext(m_f3, m_bo, bus.ld_data));
               m_pend = 1'b0;
            end
         end else if (bus.in_valid && !bus.flush) begin
            if (bus.in_wb_sel == 2'd1 && !bus.ld_valid) begin
               m_pend = 1'b1;
               m_rd = bus.in_rd; m_rw = bus.in_regwrite; m_f3 = bus.in_funct3; m_bo = bus.in_boff;
            end else begin
               m_commit(bus.in_rd, bus.in_regwrite,
                        m_sel(bus.in_wb_sel, bus.in_alu, m_ext(bus.in_funct3, bus.in_boff, bus.ld_data),
                              bus.in_pc4, bus.in_csr));
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (run) begin
         check("rf_we",        64'(bus.rf_we),    64'(e_we));
         check("rf_waddr",     64'(bus.rf_waddr), 64'(e_wa));
         check("rf_wdata",     64'(bus.rf_wdata), 64'(e_wd));
         check("instret",      bus.instret,       e_cnt);
         check("instret_wrap", 64'(bus2.instret), 64'(e_cnt[3:0]));
         check("in_ready",     64'(bus.in_ready), 64'(!m_pend && !bus.flush && !rst));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 0; bus.in_rd = '0; bus.in_regwrite = 0; bus.in_wb_sel = '0;
      bus.in_alu = '0; bus.in_pc4 = '0; bus.in_csr = '0; bus.in_funct3 = '0; bus.in_boff = '0;
      bus.ld_valid = 0; bus.ld_data = '0; bus.flush = 0;
   endtask

   task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] bo,
                       input bit ldv, input logic [31:0] d);
      bus.in_valid = 1; bus.in_rd = rd; bus.in_regwrite = 1; bus.in_wb_sel = 2'd1;
      bus.in_funct3 = f3; bus.in_boff = bo; bus.ld_valid = ldv; bus.ld_data = d;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      run = 1'b1;
      tick();
      @(negedge clk);
      check("reset rf_we",   64'(bus.rf_we), 64'd0);
      check("reset wdata",   64'(bus.rf_wdata), 64'd0);
      check("reset instret", bus.instret, 64'd0);

      // T1: ALU op
      tick(); rst = 1'b0;
      bus.in_valid = 1; bus.in_rd = 5'd5; bus.in_regwrite = 1; bus.in_wb_sel = 2'd0; bus.in_alu = 32'h1234;
      @(negedge clk);
      check("T1 ready", 64'(bus.in_ready), 64'd1);
      tick(); idle();
      @(negedge clk);
      check("T1 we",      64'(bus.rf_we), 64'd1);
      check("T1 waddr",   64'(bus.rf_waddr), 64'd5);
      check("T1 wdata",   64'(bus.rf_wdata), 64'h0000_1234);
      check("T1 instret", bus.instret, 64'd1);

      // T2: LB then LBU with same-cycle data
      tick(); load(5'd3, 3'b000, 3'd2, 1'b1, 32'h0080_0000);
      tick(); idle();
      @(negedge clk);
      check("T2 LB wdata", 64'(bus.rf_wdata), 64'hFFFF_FF80);
      tick(); load(5'd3, 3'b100, 3'd2, 1'b1, 32'h0080_0000);
      tick(); idle();
      @(negedge clk);
      check("T2 LBU wdata", 64'(bus.rf_wdata), 64'h0000_0080);
      check("T2 instret",   bus.instret, 64'd3);

      // T3: LW waiting three cycles for data
      tick(); load(5'd7, 3'b010, 3'd0, 1'b0, 32'h0);
      tick(); idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("T3 stall ready", 64'(bus.in_ready), 64'd0);
         check("T3 stall we",    64'(bus.rf_we), 64'd0);
         tick();
      end
      bus.ld_valid = 1; bus.ld_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("T3 ready at data", 64'(bus.in_ready), 64'd0);
      tick(); idle();
      @(negedge clk);
      check("T3 we",      64'(bus.rf_we), 64'd1);
      check("T3 waddr",   64'(bus.rf_waddr), 64'd7);
      check("T3 wdata",   64'(bus.rf_wdata), 64'hDEAD_BEEF);
      check("T3 ready",   64'(bus.in_ready), 64'd1);
      check("T3 instret", bus.instret, 64'd4);

      // T4: rd=0 with PC+4 select
      tick();
      bus.in_valid = 1; bus.in_rd = 5'd0; bus.in_regwrite = 1; bus.in_wb_sel = 2'd2; bus.in_pc4 = 32'h100;
      tick(); idle();
      @(negedge clk);
      check("T4 we",      64'(bus.rf_we), 64'd0);
      check("T4 wdata",   64'(bus.rf_wdata), 64'hDEAD_BEEF);
      check("T4 instret", bus.instret, 64'd5);

      // T5: flush together with ld_valid kills the pending load
      tick(); load(5'd9, 3'b010, 3'd0, 1'b0, 32'h0);
      tick(); idle();
      bus.flush = 1; bus.ld_valid = 1; bus.ld_data = 32'h55;
      @(negedge clk);
      check("T5 flush ready", 64'(bus.in_ready), 64'd0);
      tick(); idle();
      @(negedge clk);
      check("T5 we",      64'(bus.rf_we), 64'd0);
      check("T5 instret", bus.instret, 64'd5);
      check("T5 ready",   64'(bus.in_ready), 64'd1);

      // T6: reset while waiting for a load
      tick(); load(5'd10, 3'b010, 3'd0, 1'b0, 32'h0);
      tick(); idle(); rst = 1'b1;
      tick(); rst = 1'b0;
      @(negedge clk);
      check("T6 we",      64'(bus.rf_we), 64'd0);
      check("T6 waddr",   64'(bus.rf_waddr), 64'd0);
      check("T6 wdata",   64'(bus.rf_wdata), 64'd0);
      check("T6 instret", bus.instret, 64'd0);
      check("T6 ready",   64'(bus.in_ready), 64'd1);
      tick(); bus.ld_valid = 1; bus.ld_data = 32'h77;
      tick(); idle();
      @(negedge clk);
      check("T6 late ld we",      64'(bus.rf_we), 64'd0);
      check("T6 late ld instret", bus.instret, 64'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst              = ($urandom_range(0, 199) == 0);
         bus.in_valid     = ($urandom_range(0, 3) != 0);
         bus.in_rd        = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
         bus.in_regwrite  = ($urandom_range(0, 4) != 0);
         bus.in_wb_sel    = 2'($urandom);
         bus.in_alu       = $urandom;
         bus.in_pc4       = $urandom;
         bus.in_csr       = $urandom;
         bus.in_funct3    = 3'($urandom);
         bus.in_boff      = 3'($urandom);
         bus.ld_valid     = ($urandom_range(0, 1) == 0);
         bus.ld_data      = $urandom;
         bus.flush        = ($urandom_range(0, 9) == 0);
      end
      tick(); idle(); rst = 1'b0;
      tick(); tick();
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
